// File: rtl/thermo_bar_meter_if.sv
// Level-in / segment-out bundle for the thermometer bar-graph meter.
// The master side supplies samples and the display mode. The slave side
// returns the segment pattern, the valid pulse and the peak marker.
interface thermo_bar_meter_if #(
    parameter int IN_W = 4
);
    localparam int SEGS = (1 << IN_W) - 1;

    logic            in_valid;
    logic [IN_W-1:0] in_value;
    logic [1:0]      mode;
    logic            out_valid;
    logic [SEGS-1:0] therm;
    logic [IN_W-1:0] peak;

    modport master (
        output in_valid,
        output in_value,
        output mode,
        input  out_valid,
        input  therm,
        input  peak
    );

    modport slave (
        input  in_valid,
        input  in_value,
        input  mode,
        output out_valid,
        output therm,
        output peak
    );
endinterface

// File: rtl/thermo_bar_meter.sv
// Thermometer bar-graph driver with a VU-meter style peak-hold/decay marker.
//
//  state | meaning
//  IDLE  | peak equals the level; no timer is running
//  HOLD  | the level dropped below the peak; the peak is frozen while hold_cnt runs down
//  DECAY | the peak steps down by one each time decay_cnt expires, until it meets the level
module thermo_bar_meter #(
    parameter int IN_W         = 4,
    parameter int HOLD_CYCLES  = 8,
    parameter int DECAY_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    thermo_bar_meter_if.slave bus
);
    localparam int SEGS    = (1 << IN_W) - 1;
    localparam int HOLD_W  = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
    localparam int DECAY_W = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DECAY_W-1:0] DECAY_LOAD = DECAY_W'(DECAY_CYCLES - 1);
    localparam logic [SEGS-1:0]    SEG_ONE    = SEGS'(1);

    localparam logic [1:0] MODE_BAR      = 2'b00;
    localparam logic [1:0] MODE_DOT      = 2'b01;
    localparam logic [1:0] MODE_BAR_PEAK = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        HOLD  = 2'b01,
        DECAY = 2'b10
    } state_t;

    state_t             state_q, state_nxt;
    logic [IN_W-1:0]    level_q, level_nxt;
    logic [IN_W-1:0]    peak_q, peak_nxt, peak_dec;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_nxt;
    logic [DECAY_W-1:0] decay_cnt_q, decay_nxt;
    logic [SEGS-1:0]    therm_q, therm_nxt;
    logic               out_valid_q;

    // A sample this edge is already the level seen by the peak logic and the pattern.
    assign level_nxt = bus.in_valid ? bus.in_value : level_q;
    assign peak_dec  = peak_q - 1'b1;

    // State register: FSM state, level, peak and both down-counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            level_q     <= '0;
            peak_q      <= '0;
            hold_cnt_q  <= '0;
            decay_cnt_q <= '0;
        end else begin
            state_q     <= state_nxt;
            level_q     <= level_nxt;
            peak_q      <= peak_nxt;
            hold_cnt_q  <= hold_nxt;
            decay_cnt_q <= decay_nxt;
        end
    end

    // Next-state logic: a sample at or above the peak overrides any pending timer event.
    always_comb begin
        state_nxt = state_q;
        peak_nxt  = peak_q;
        hold_nxt  = hold_cnt_q;
        decay_nxt = decay_cnt_q;
        if (bus.in_valid && (bus.in_value >= peak_q)) begin
            state_nxt = IDLE;
            peak_nxt  = bus.in_value;
            hold_nxt  = '0;
            decay_nxt = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_nxt = HOLD;
                        hold_nxt  = HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == '0) begin
                        state_nxt = DECAY;
                        decay_nxt = DECAY_LOAD;
                    end else begin
                        hold_nxt = hold_cnt_q - 1'b1;
                    end
                end
                DECAY: begin
                    if (decay_cnt_q == '0) begin
                        if (peak_q > level_nxt) begin
                            peak_nxt  = peak_dec;
                            decay_nxt = DECAY_LOAD;
                            if (peak_dec == level_nxt) begin
                                state_nxt = IDLE;
                                decay_nxt = '0;
                            end
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        decay_nxt = decay_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Output logic: segment pattern built from the next level/peak and the current mode.
    logic [SEGS:0]   bar_ext;
    logic [SEGS-1:0] bar_v, dot_v, dot_p;
    always_comb begin
        bar_ext = ({{SEGS{1'b0}}, 1'b1} << level_nxt) - 1'b1;
        bar_v   = bar_ext[SEGS-1:0];
        dot_v   = (level_nxt != '0) ? (SEG_ONE << (level_nxt - 1'b1)) : '0;
        dot_p   = (peak_nxt  != '0) ? (SEG_ONE << (peak_nxt  - 1'b1)) : '0;
        case (bus.mode)
            MODE_BAR:      therm_nxt = bar_v;
            MODE_DOT:      therm_nxt = dot_v;
            MODE_BAR_PEAK: therm_nxt = bar_v | dot_p;
            default:       therm_nxt = dot_p;
        endcase
    end

    // Output register: the pattern refreshes every cycle, the valid pulse follows the sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            therm_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            therm_q     <= therm_nxt;
            out_valid_q <= bus.in_valid;
        end
    end

    assign bus.therm     = therm_q;
    assign bus.out_valid = out_valid_q;
    assign bus.peak      = peak_q;
endmodule
